mips_mc_control: RTL and testbench

Parametrised multicycle control unit for the team's MIPS core. It drives the datapath of PC, instruction register, ALU, register file and memory through fetch, decode and up to three execute states. It adds three things on top of the fixed five-state decoder:
- memory wait-state handshake;
- an illegal-opcode trap and a PC-zero halt;
- optional HI/LO multiply/divide sequencing.

---
 rtl/mips_mc_control_if.sv | 34 +++
 rtl/mips_mc_control.sv | 170 +++++++++++++++++
 tb/tb_mips_mc_control.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_control_if.sv
// mips_mc_control_if: control bus (master=control unit: in start/instr/mem_waitrequest/pc_zero[/md_busy], out strobes, muxes, alu_op, branch_type[, md_start/md_op/hilo_sel]; md signals only with MIPS_MC_MULTDIV_EN)
interface mips_mc_control_if #(parameter int ALUOP_W = 4);
  logic start, mem_waitrequest, pc_zero, active, illegal, ir_write, pc_write, pc_write_cond;
  logic iord, mem_read, mem_write, reg_write, alu_src_a, imm_zext;
  logic [31:0] instr;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] branch_type;
  logic [ALUOP_W-1:0] alu_op;
`ifdef MIPS_MC_MULTDIV_EN
  logic md_busy, md_start, hilo_sel;
  logic [1:0] md_op;
  modport master(
    input start, instr, mem_waitrequest, pc_zero, md_busy,
    output active, illegal, ir_write, pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write,
    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_op, branch_type, md_start, md_op, hilo_sel
  );
  modport slave(
    output start, instr, mem_waitrequest, pc_zero, md_busy,
    input active, illegal, ir_write, pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write,
    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_op, branch_type, md_start, md_op, hilo_sel
  );
`else
  modport master(
    input start, instr, mem_waitrequest, pc_zero,
    output active, illegal, ir_write, pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write,
    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_op, branch_type
  );
  modport slave(
    output start, instr, mem_waitrequest, pc_zero,
    input active, illegal, ir_write, pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write,
    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_op, branch_type
  );
`endif
endinterface

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS control FSM with wait states, illegal trap, pc-zero halt (ports clk, reset, bus master; optional MIPS_MC_MULTDIV_EN adds HI/LO sequencing)
module mips_mc_control #(
  parameter int START_ON_RESET  = 1,
  parameter int HALT_ON_ILLEGAL = 0,
  parameter int ALUOP_W         = 4
) (
  input logic clk,
  input logic reset,
  mips_mc_control_if.master bus
);
`ifdef MIPS_MC_MULTDIV_EN
  typedef enum logic [2:0] {HALTED, FETCH, DECODE, EXEC_1, EXEC_2, EXEC_3, MD_WAIT} state_t;
`else
  typedef enum logic [2:0] {HALTED, FETCH, DECODE, EXEC_1, EXEC_2, EXEC_3} state_t;
`endif
  state_t st, nxt;
  logic [5:0] op, fn;
  logic is_r, r_alu, i_alu, is_lw, is_sw, is_br, is_j, is_jal, is_jr, is_jalr, is_md, is_mf, legal, unused;
  logic [3:0] r_op, i_op;
  assign op = bus.instr[31:26];
  assign fn = bus.instr[5:0];
  assign unused = ^bus.instr[25:6];
  assign is_r = op == 6'h00;
  assign r_alu = is_r && (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h2b});
  assign is_jr = is_r && fn == 6'h08;
  assign is_jalr = is_r && fn == 6'h09;
  assign i_alu = op inside {[6'h09:6'h0f]};
  assign is_lw = op == 6'h23;
  assign is_sw = op == 6'h2b;
  assign is_br = op inside {[6'h04:6'h07]};
  assign is_j = op == 6'h02;
  assign is_jal = op == 6'h03;
`ifdef MIPS_MC_MULTDIV_EN
  assign is_md = is_r && (fn inside {[6'h18:6'h1b]});
  assign is_mf = is_r && (fn == 6'h10 || fn == 6'h12);
`else
  assign is_md = 1'b0;
  assign is_mf = 1'b0;
`endif
  assign legal = r_alu | i_alu | is_lw | is_sw | is_br | is_j | is_jal | is_jr | is_jalr | is_md | is_mf;
  assign r_op = fn == 6'h23 ? 4'd1 : fn == 6'h24 ? 4'd2 : fn == 6'h25 ? 4'd3 : fn == 6'h26 ? 4'd4 :
                fn == 6'h2a ? 4'd5 : fn == 6'h2b ? 4'd6 : (fn inside {6'h00, 6'h04}) ? 4'd7 :
                (fn inside {6'h02, 6'h06}) ? 4'd8 : (fn inside {6'h03, 6'h07}) ? 4'd9 : 4'd0;
  assign i_op = op == 6'h0a ? 4'd5 : op == 6'h0b ? 4'd6 : op == 6'h0c ? 4'd2 : op == 6'h0d ? 4'd3 :
                op == 6'h0e ? 4'd4 : op == 6'h0f ? 4'd10 : 4'd0;
  always_ff @(posedge clk)
    if (reset) st <= START_ON_RESET != 0 ? FETCH : HALTED;
    else st <= nxt;
  always_comb begin
    nxt = st;
    bus.active = 1'b1;
    bus.illegal = 1'b0;
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src = 2'd0;
    bus.iord = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_dst = 2'd0;
    bus.mem_to_reg = 2'd0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'd0;
    bus.imm_zext = 1'b0;
    bus.alu_op = '0;
    bus.branch_type = 3'd0;
`ifdef MIPS_MC_MULTDIV_EN
    bus.md_start = 1'b0;
    bus.md_op = 2'd0;
    bus.hilo_sel = 1'b0;
`endif
    case (st)
      HALTED: begin
        bus.active = 1'b0;
        nxt = bus.start ? FETCH : HALTED;
      end
      FETCH:
        if (bus.pc_zero) nxt = HALTED;
        else begin
          bus.mem_read = 1'b1;
          if (!bus.mem_waitrequest) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            bus.alu_src_b = 2'd1;
            nxt = DECODE;
          end
        end
      DECODE: begin
        bus.alu_src_b = 2'd3;
        bus.illegal = !legal;
`ifdef MIPS_MC_MULTDIV_EN
        nxt = !legal ? (HALT_ON_ILLEGAL != 0 ? HALTED : FETCH) : (is_mf && bus.md_busy) ? MD_WAIT : EXEC_1;
`else
        nxt = !legal ? (HALT_ON_ILLEGAL != 0 ? HALTED : FETCH) : EXEC_1;
`endif
      end
      EXEC_1: begin
        nxt = FETCH;
        if (r_alu) begin
          bus.alu_src_a = 1'b1;
          bus.alu_op = ALUOP_W'(r_op);
          nxt = EXEC_2;
        end else if (i_alu || is_lw || is_sw) begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'd2;
          bus.alu_op = i_alu ? ALUOP_W'(i_op) : '0;
          bus.imm_zext = op inside {6'h0c, 6'h0d, 6'h0e};
          nxt = EXEC_2;
        end else if (is_br) begin
          bus.alu_src_a = 1'b1;
          bus.alu_op = ALUOP_W'(1);
          bus.pc_write_cond = 1'b1;
          bus.pc_src = 2'd1;
          bus.branch_type = {1'b0, op[1], op[1] ^ op[0]};
        end else if (is_j || is_jal || is_jr || is_jalr) begin
          bus.pc_src = (is_j || is_jal) ? 2'd2 : 2'd3;
          bus.pc_write = 1'b1;
          bus.reg_write = is_jal || is_jalr;
          bus.reg_dst = is_jal ? 2'd2 : is_jalr ? 2'd1 : 2'd0;
          bus.mem_to_reg = (is_jal || is_jalr) ? 2'd2 : 2'd0;
        end
`ifdef MIPS_MC_MULTDIV_EN
        else if (is_md) begin
          bus.md_start = 1'b1;
          bus.md_op = fn[1:0];
          nxt = MD_WAIT;
        end else if (is_mf) begin
          bus.reg_dst = 2'd1;
          bus.mem_to_reg = 2'd3;
          bus.hilo_sel = ~fn[1];
          bus.reg_write = 1'b1;
        end
`endif
      end
      EXEC_2:
        if (is_lw || is_sw) begin
          bus.iord = 1'b1;
          bus.mem_read = is_lw;
          bus.mem_write = is_sw;
          if (!bus.mem_waitrequest) nxt = is_lw ? EXEC_3 : FETCH;
        end else begin
          bus.reg_dst = r_alu ? 2'd1 : 2'd0;
          bus.reg_write = 1'b1;
          nxt = FETCH;
        end
      EXEC_3: begin
        bus.mem_to_reg = 2'd1;
        bus.reg_write = 1'b1;
        nxt = FETCH;
      end
`ifdef MIPS_MC_MULTDIV_EN
      MD_WAIT: nxt = bus.md_busy ? MD_WAIT : is_mf ? EXEC_1 : FETCH;
`endif
      default: nxt = FETCH;
    endcase
    if (reset) begin
      bus.illegal = 1'b0;
      bus.ir_write = 1'b0;
      bus.pc_write = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
      bus.reg_write = 1'b0;
`ifdef MIPS_MC_MULTDIV_EN
      bus.md_start = 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: directed bench for mips_mc_control (default and halting/start-gated instances)
module tb_mips_mc_control;
  localparam logic [6:0] FETCH_S = 7'b1101000;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, wr = 1'b0, pcz = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [6:0] sa, sb;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mips_mc_control_if #(.ALUOP_W(4)) ifa ();
  mips_mc_control_if #(.ALUOP_W(4)) ifb ();
  assign ifa.start = start;
  assign ifa.instr = instr;
  assign ifa.mem_waitrequest = wr;
  assign ifa.pc_zero = pcz;
  assign ifb.start = start;
  assign ifb.instr = instr;
  assign ifb.mem_waitrequest = wr;
  assign ifb.pc_zero = pcz;
`ifdef MIPS_MC_MULTDIV_EN
  logic mdb = 1'b0;
  assign ifa.md_busy = mdb;
  assign ifb.md_busy = mdb;
`endif
  assign sa = {ifa.ir_write, ifa.pc_write, ifa.pc_write_cond, ifa.mem_read, ifa.mem_write, ifa.reg_write, ifa.illegal};
  assign sb = {ifb.ir_write, ifb.pc_write, ifb.pc_write_cond, ifb.mem_read, ifb.mem_write, ifb.reg_write, ifb.illegal};
  mips_mc_control dut (.clk(clk), .reset(reset), .bus(ifa));
  mips_mc_control #(.START_ON_RESET(0), .HALT_ON_ILLEGAL(1)) dut_h (.clk(clk), .reset(reset), .bus(ifb));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; wr = 1'b0; pcz = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    total++; if (sa !== 7'b0) begin bad++; $display("FAIL reset_strobes got=%b want=%b", sa, 7'b0); end
    total++; if ({ifa.active, ifb.active} !== 2'b10) begin bad++; $display("FAIL reset_active got=%b want=%b", {ifa.active, ifb.active}, 2'b10); end
    reset = 1'b0;
    #1;
    total++; if (sa !== FETCH_S) begin bad++; $display("FAIL reset_fetch got=%b want=%b", sa, FETCH_S); end
    total++; if (sb !== 7'b0) begin bad++; $display("FAIL reset_halted_strobes got=%b want=%b", sb, 7'b0); end
  endtask

  task automatic test_addu;
    do_reset();
    instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    #1;
    total++; if (sa !== FETCH_S || ifa.alu_src_b !== 2'd1) begin bad++; $display("FAIL addu_c1 got=%b/%0d want=%b/1", sa, ifa.alu_src_b, FETCH_S); end
    tick();
    total++; if (sa !== 7'b0 || ifa.alu_src_b !== 2'd3) begin bad++; $display("FAIL addu_c2 got=%b/%0d want=0/3", sa, ifa.alu_src_b); end
    tick();
    total++; if (sa !== 7'b0 || {ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op} !== 7'b1000000) begin bad++; $display("FAIL addu_c3 got=%b a=%b b=%0d op=%0d want a=1 b=0 op=0", sa, ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op); end
    tick();
    total++; if (sa !== 7'b0000010 || ifa.reg_dst !== 2'd1 || ifa.alu_op !== 4'd0) begin bad++; $display("FAIL addu_c4 got=%b dst=%0d op=%0d want=0000010 dst=1 op=0", sa, ifa.reg_dst, ifa.alu_op); end
    tick();
    total++; if (sa !== FETCH_S) begin bad++; $display("FAIL addu_c5 got=%b want=%b", sa, FETCH_S); end
  endtask

  task automatic test_rtype;
    logic [5:0] fns [13] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07};
    logic [3:0] ops [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd8, 4'd8, 4'd9, 4'd9};
    for (int i = 0; i < 13; i++) begin
      do_reset();
      instr = {6'h00, 5'd4, 5'd5, 5'd6, 5'd2, fns[i]};
      tick();
      tick();
      total++; if (ifa.alu_op !== ops[i] || ifa.alu_src_a !== 1'b1 || ifa.alu_src_b !== 2'd0) begin bad++; $display("FAIL rtype_op fn=%h got=%0d a=%b b=%0d want=%0d", fns[i], ifa.alu_op, ifa.alu_src_a, ifa.alu_src_b, ops[i]); end
      tick();
      total++; if (sa !== 7'b0000010 || ifa.reg_dst !== 2'd1) begin bad++; $display("FAIL rtype_wb fn=%h got=%b dst=%0d want=0000010 dst=1", fns[i], sa, ifa.reg_dst); end
    end
  endtask

  task automatic test_itype;
    logic [5:0] opc [7] = '{6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    logic [3:0] ops [7] = '{4'd0, 4'd5, 4'd6, 4'd2, 4'd3, 4'd4, 4'd10};
    logic zx [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      instr = {opc[i], 5'd1, 5'd2, 16'h8001};
      tick();
      tick();
      total++; if (ifa.alu_op !== ops[i] || ifa.imm_zext !== zx[i] || ifa.alu_src_a !== 1'b1 || ifa.alu_src_b !== 2'd2) begin bad++; $display("FAIL itype_op op=%h got=%0d z=%b b=%0d want=%0d z=%b b=2", opc[i], ifa.alu_op, ifa.imm_zext, ifa.alu_src_b, ops[i], zx[i]); end
      tick();
      total++; if (sa !== 7'b0000010 || ifa.reg_dst !== 2'd0) begin bad++; $display("FAIL itype_wb op=%h got=%b dst=%0d want=0000010 dst=0", opc[i], sa, ifa.reg_dst); end
    end
  endtask

  task automatic test_lw_wait;
    int rd = 0, rw = 0;
    do_reset();
    instr = {6'h23, 5'd1, 5'd2, 16'h0010};
    tick();
    tick();
    total++; if ({ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op} !== 7'b1100000) begin bad++; $display("FAIL lw_addr got a=%b b=%0d op=%0d want a=1 b=2 op=0", ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op); end
    tick();
    for (int c = 0; c < 3; c++) begin
      wr = c < 2;
      #1;
      rd += int'(ifa.mem_read && ifa.iord);
      rw += int'(ifa.reg_write);
      tick();
    end
    wr = 1'b0;
    total++; if (rd !== 3) begin bad++; $display("FAIL lw_read_cycles got=%0d want=3", rd); end
    total++; if (sa !== 7'b0000010 || ifa.mem_to_reg !== 2'd1) begin bad++; $display("FAIL lw_wb got=%b m2r=%0d want=0000010 m2r=1", sa, ifa.mem_to_reg); end
    rw += int'(ifa.reg_write);
    tick();
    total++; if (sa !== FETCH_S) begin bad++; $display("FAIL lw_end got=%b want=%b", sa, FETCH_S); end
    total++; if (rw !== 1) begin bad++; $display("FAIL lw_reg_write_count got=%0d want=1", rw); end
  endtask

  task automatic test_sw;
    do_reset();
    instr = {6'h2b, 5'd1, 5'd2, 16'h0004};
    tick();
    tick();
    tick();
    wr = 1'b1;
    #1;
    total++; if (sa !== 7'b0000100 || ifa.iord !== 1'b1) begin bad++; $display("FAIL sw_wait got=%b iord=%b want=0000100 iord=1", sa, ifa.iord); end
    tick();
    wr = 1'b0;
    #1;
    total++; if (sa !== 7'b0000100 || ifa.iord !== 1'b1) begin bad++; $display("FAIL sw_done got=%b iord=%b want=0000100 iord=1", sa, ifa.iord); end
    tick();
    total++; if (sa !== FETCH_S) begin bad++; $display("FAIL sw_end got=%b want=%b", sa, FETCH_S); end
  endtask

  task automatic test_branch_jump;
    logic [5:0] bop [4] = '{6'h04, 6'h05, 6'h06, 6'h07};
    logic [2:0] bt [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      instr = {bop[i], 5'd1, 5'd2, 16'hfffe};
      tick();
      tick();
      total++; if (sa !== 7'b0010000 || ifa.branch_type !== bt[i] || ifa.pc_src !== 2'd1 || ifa.alu_op !== 4'd1 || ifa.alu_src_a !== 1'b1) begin bad++; $display("FAIL branch op=%h got=%b bt=%0d src=%0d aluop=%0d want=0010000 bt=%0d src=1 aluop=1", bop[i], sa, ifa.branch_type, ifa.pc_src, ifa.alu_op, bt[i]); end
      tick();
      total++; if (sa !== FETCH_S) begin bad++; $display("FAIL branch_end op=%h got=%b want=%b", bop[i], sa, FETCH_S); end
    end
    do_reset();
    instr = {6'h03, 26'h0000040};
    tick();
    tick();
    total++; if (sa !== 7'b0100010 || ifa.reg_dst !== 2'd2 || ifa.mem_to_reg !== 2'd2 || ifa.pc_src !== 2'd2) begin bad++; $display("FAIL jal got=%b dst=%0d m2r=%0d src=%0d want=0100010 2 2 2", sa, ifa.reg_dst, ifa.mem_to_reg, ifa.pc_src); end
    tick();
    total++; if (sa !== FETCH_S) begin bad++; $display("FAIL jal_end got=%b want=%b", sa, FETCH_S); end
    do_reset();
    instr = {6'h00, 5'd7, 15'd0, 6'h08};
    tick();
    tick();
    total++; if (sa !== 7'b0100000 || ifa.pc_src !== 2'd3) begin bad++; $display("FAIL jr got=%b src=%0d want=0100000 src=3", sa, ifa.pc_src); end
    do_reset();
    instr = {6'h00, 5'd7, 5'd0, 5'd31, 5'd0, 6'h09};
    tick();
    tick();
    total++; if (sa !== 7'b0100010 || ifa.pc_src !== 2'd3 || ifa.reg_dst !== 2'd1 || ifa.mem_to_reg !== 2'd2) begin bad++; $display("FAIL jalr got=%b src=%0d dst=%0d m2r=%0d want=0100010 3 1 2", sa, ifa.pc_src, ifa.reg_dst, ifa.mem_to_reg); end
  endtask

  task automatic test_halt_start_illegal;
    do_reset();
    pcz = 1'b1;
    #1;
    total++; if (sa !== 7'b0 || ifa.active !== 1'b1) begin bad++; $display("FAIL pcz_fetch got=%b act=%b want=0 act=1", sa, ifa.active); end
    tick();
    pcz = 1'b0;
    tick();
    total++; if ({ifa.active, ifb.active} !== 2'b00 || sa !== 7'b0) begin bad++; $display("FAIL pcz_halted got act=%b%b s=%b want=00 0", ifa.active, ifb.active, sa); end
    start = 1'b1;
    tick();
    start = 1'b0;
    instr = {6'h3f, 26'h0};
    #1;
    total++; if ({ifa.active, ifb.active} !== 2'b11 || sa !== FETCH_S || sb !== FETCH_S) begin bad++; $display("FAIL start_fetch got act=%b%b sa=%b sb=%b want=11 %b", ifa.active, ifb.active, sa, sb, FETCH_S); end
    tick();
    total++; if (sa !== 7'b0000001 || sb !== 7'b0000001) begin bad++; $display("FAIL illegal_pulse got sa=%b sb=%b want=0000001", sa, sb); end
    tick();
    total++; if (sa !== FETCH_S) begin bad++; $display("FAIL illegal_resume got=%b want=%b", sa, FETCH_S); end
    total++; if (ifb.active !== 1'b0 || sb !== 7'b0) begin bad++; $display("FAIL illegal_halt got act=%b s=%b want=0 0", ifb.active, sb); end
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    #1;
    total++; if (ifb.active !== 1'b0) begin bad++; $display("FAIL reset_beats_start got=%b want=0", ifb.active); end
    do_reset();
    instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (ifa.alu_src_a !== 1'b1 || sa !== 7'b0) begin bad++; $display("FAIL start_ignored got a=%b s=%b want a=1 s=0", ifa.alu_src_a, sa); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    instr = {6'h23, 5'd1, 5'd2, 16'h0010};
    tick();
    tick();
    tick();
    wr = 1'b1;
    reset = 1'b1;
    #1;
    total++; if (sa !== 7'b0) begin bad++; $display("FAIL reset_mid_strobes got=%b want=0", sa); end
    tick();
    reset = 1'b0;
    wr = 1'b0;
    #1;
    total++; if (sa !== FETCH_S) begin bad++; $display("FAIL reset_mid_fetch got=%b want=%b", sa, FETCH_S); end
  endtask

`ifdef MIPS_MC_MULTDIV_EN
  task automatic test_multdiv;
    int ms = 0;
    do_reset();
    instr = {6'h00, 5'd1, 5'd2, 10'd0, 6'h18};
    tick();
    tick();
    mdb = 1'b1;
    #1;
    total++; if (ifa.md_start !== 1'b1 || ifa.md_op !== 2'd0) begin bad++; $display("FAIL md_start got=%b op=%0d want=1 0", ifa.md_start, ifa.md_op); end
    tick();
    for (int c = 0; c < 10; c++) begin
      mdb = c < 9;
      #1;
      ms += int'(ifa.md_start) + int'(sa != 7'b0);
      tick();
    end
    mdb = 1'b0;
    total++; if (ms !== 0) begin bad++; $display("FAIL md_wait_quiet got=%0d want=0", ms); end
    total++; if (sa !== FETCH_S) begin bad++; $display("FAIL md_end got=%b want=%b", sa, FETCH_S); end
    instr = {6'h00, 10'd0, 5'd3, 5'd0, 6'h12};
    tick();
    tick();
    total++; if (sa !== 7'b0000010 || ifa.hilo_sel !== 1'b0 || ifa.mem_to_reg !== 2'd3 || ifa.reg_dst !== 2'd1) begin bad++; $display("FAIL mflo got=%b hl=%b m2r=%0d dst=%0d want=0000010 0 3 1", sa, ifa.hilo_sel, ifa.mem_to_reg, ifa.reg_dst); end
  endtask
`else
  task automatic test_multdiv;
    do_reset();
    instr = {6'h00, 5'd1, 5'd2, 10'd0, 6'h18};
    tick();
    total++; if (sa !== 7'b0000001) begin bad++; $display("FAIL mult_illegal got=%b want=0000001", sa); end
    instr = {6'h00, 10'd0, 5'd3, 5'd0, 6'h10};
    tick();
    tick();
    total++; if (sa !== 7'b0000001) begin bad++; $display("FAIL mfhi_illegal got=%b want=0000001", sa); end
  endtask
`endif

  initial begin
    test_reset();
    test_addu();
    test_rtype();
    test_itype();
    test_lw_wait();
    test_sw();
    test_branch_jump();
    test_halt_start_illegal();
    test_reset_mid();
    test_multdiv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
